// File: rtl/delta_calc.sv
// Backprop error stage: output-layer and hidden-layer deltas feeding weight_bias_calc.
// One shared saturating Q-format multiplier is time-multiplexed by a two-process FSM.
module delta_calc #(
  parameter int unsigned N_HL_P = 3,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [N_OUT*WIDTH-1:0]          i_t,
  input  logic [N_OUT*WIDTH-1:0]          i_out_a,
  input  logic [N_HL_P*WIDTH-1:0]         i_hd_a,
  input  logic [N_HL_P*N_OUT*WIDTH-1:0]   i_wght_o,
  output logic [N_OUT*WIDTH-1:0]          o_dlto,
  output logic [N_HL_P*WIDTH-1:0]         o_dlth,
  output logic                            o_busy,
  output logic                            o_valid
);

  localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned IW = (N_HL_P > 1) ? $clog2(N_HL_P) : 1;
  localparam int unsigned OW = N_OUT * WIDTH;
  localparam int unsigned HW = N_HL_P * WIDTH;
  localparam int unsigned WW = N_HL_P * N_OUT * WIDTH;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_OD, S_OE, S_HM, S_HD, S_HE} state_t;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sub);
    logic [WIDTH:0] s;
    s = sub ? ({x[WIDTH-1], x} - {y[WIDTH-1], y}) : ({x[WIDTH-1], x} + {y[WIDTH-1], y});
    if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? MINV : MAXV;
    return s[WIDTH-1:0];
  endfunction

  // Full-width product, arithmetic shift by FRAC, clamp if upper bits are not a sign extension.
  function automatic logic [WIDTH-1:0] sat_mul(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});
    p = p >>> FRAC;
    if ((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1])) return p[WIDTH-1:0];
    return p[2*WIDTH-1] ? MINV : MAXV;
  endfunction

  state_t           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [IW-1:0]    i_q, i_d;
  logic [OW-1:0]    t_q, t_d, a_q, a_d;
  logic [HW-1:0]    h_q, h_d;
  logic [WW-1:0]    w_q, w_d;
  logic [WIDTH-1:0] d_q, d_d, acc_q, acc_d;
  logic [OW-1:0]    dlto_w_q, dlto_w_d, dlto_q, dlto_d;
  logic [HW-1:0]    dlth_w_q, dlth_w_d, dlth_q, dlth_d;
  logic             busy_q, busy_d, valid_q, valid_d;

  logic [WIDTH-1:0] a_j, t_j, h_i, w_ji, mul_x, mul_y, mul_p;

  // Shared multiplier operand select
  always_comb begin
    a_j   = a_q[j_q*WIDTH +: WIDTH];
    t_j   = t_q[j_q*WIDTH +: WIDTH];
    h_i   = h_q[i_q*WIDTH +: WIDTH];
    w_ji  = w_q[(j_q*N_HL_P + i_q)*WIDTH +: WIDTH];
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      S_OD: begin mul_x = a_j;                   mul_y = sat_add(ONE, a_j, 1'b1); end
      S_OE: begin mul_x = sat_add(a_j, t_j, 1'b1); mul_y = d_q; end
      S_HM: begin mul_x = w_ji;                  mul_y = dlto_w_q[j_q*WIDTH +: WIDTH]; end
      S_HD: begin mul_x = h_i;                   mul_y = sat_add(ONE, h_i, 1'b1); end
      S_HE: begin mul_x = acc_q;                 mul_y = d_q; end
      default: ;
    endcase
    mul_p = sat_mul(mul_x, mul_y);
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    i_d      = i_q;
    t_d      = t_q;
    a_d      = a_q;
    h_d      = h_q;
    w_d      = w_q;
    d_d      = d_q;
    acc_d    = acc_q;
    dlto_w_d = dlto_w_q;
    dlth_w_d = dlth_w_q;
    dlto_d   = dlto_q;
    dlth_d   = dlth_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          t_d     = i_t;
          a_d     = i_out_a;
          h_d     = i_hd_a;
          w_d     = i_wght_o;
          j_d     = '0;
          i_d     = '0;
          acc_d   = '0;
          state_d = S_OD;
        end
      end
      S_OD: begin
        d_d     = mul_p;
        state_d = S_OE;
      end
      S_OE: begin
        dlto_w_d[j_q*WIDTH +: WIDTH] = mul_p;
        if (j_q == JW'(N_OUT - 1)) begin
          j_d     = '0;
          acc_d   = '0;
          state_d = S_HM;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = S_OD;
        end
      end
      S_HM: begin
        acc_d = sat_add(acc_q, mul_p, 1'b0);
        if (j_q == JW'(N_OUT - 1)) begin
          j_d     = '0;
          state_d = S_HD;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_HD: begin
        d_d     = mul_p;
        state_d = S_HE;
      end
      S_HE: begin
        dlth_w_d[i_q*WIDTH +: WIDTH] = mul_p;
        if (i_q == IW'(N_HL_P - 1)) begin
          dlto_d  = dlto_w_q;
          dlth_d  = dlth_w_d;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          i_d     = i_q + IW'(1);
          acc_d   = '0;
          state_d = S_HM;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      j_q      <= '0;
      i_q      <= '0;
      t_q      <= '0;
      a_q      <= '0;
      h_q      <= '0;
      w_q      <= '0;
      d_q      <= '0;
      acc_q    <= '0;
      dlto_w_q <= '0;
      dlth_w_q <= '0;
      dlto_q   <= '0;
      dlth_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      i_q      <= i_d;
      t_q      <= t_d;
      a_q      <= a_d;
      h_q      <= h_d;
      w_q      <= w_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      dlto_w_q <= dlto_w_d;
      dlth_w_q <= dlth_w_d;
      dlto_q   <= dlto_d;
      dlth_q   <= dlth_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign o_dlto  = dlto_q;
  assign o_dlth  = dlth_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;

endmodule

// File: doc/delta_calc.md
Name: delta_calc

Overview:
- Backprop error stage directly upstream of weight_bias_calc.
- Computes output-layer deltas (o_dlto) and hidden-layer deltas (o_dlth) from targets, forward-pass activations and current output-layer weights.
- Its outputs drive i_dlto/i_dlth of weight_bias_calc.
- Uses one shared signed fixed-point multiplier, sequenced by an FSM.

Parameters:
N_HL_P, 3, number of hidden perceptrons
N_OUT, 2, number of output perceptrons
WIDTH, 32, data width, signed two's complement
FRAC, 24, fractional bits (Q8.24; ONE = 0x01000000)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
i_start  in  1  request new delta computation; sampled only in IDLE
i_t  in  N_OUT*WIDTH  target values; element j at [j*WIDTH +: WIDTH]
i_out_a  in  N_OUT*WIDTH  output-layer activations a_j
i_hd_a  in  N_HL_P*WIDTH  hidden activations h_i (same packing as weight_bias_calc i_hd_a)
i_wght_o  in  N_HL_P*N_OUT*WIDTH  weight hidden i -> output j at [(j*N_HL_P+i)*WIDTH +: WIDTH]
o_dlto  out  N_OUT*WIDTH  output deltas
o_dlth  out  N_HL_P*WIDTH  hidden deltas
o_busy  out  1  high while computing
o_valid  out  1  one-cycle pulse: new o_dlto/o_dlth present

Behaviour:
- Reset (rst=0, async): state IDLE; o_dlto, o_dlth, o_busy, o_valid, all working registers = 0.
- Math:
  - dlto_j = (a_j - t_j) * a_j * (ONE - a_j)
  - dlth_i = (sum_j w[j][i]*dlto_j) * h_i * (ONE - h_i)
- Multiply: full 2*WIDTH signed product, arithmetic shift right FRAC, saturate to [0x80000000, 0x7FFFFFFF].
- Add/subtract (a-t, ONE-a, accumulate): saturating, same bounds.
- Input capture: at the edge sampling i_start=1 in IDLE, all inputs are registered internally; input changes afterwards have no effect on the current run.
- FSM: IDLE -> OD -> OE (repeat per j = 0..N_OUT-1) -> HM (N_OUT cycles, j = 0..N_OUT-1) -> HD -> HE (repeat HM/HD/HE per i = 0..N_HL_P-1) -> IDLE.
  - OD: d = a_j*(ONE-a_j).
  - OE: dlto_j = (a_j-t_j)*d.
  - HM: acc = acc + w[j][i]*dlto_j; acc cleared entering each neuron.
  - HD: d = h_i*(ONE-h_i).
  - HE: dlth_i = acc*d.
- Exactly one multiply per cycle.
- Latency: L = 2*N_OUT + N_HL_P*(N_OUT+2) = 16 at defaults.
  - o_valid is high in the cycle after the L-th edge following the start-sampling edge.
  - o_dlto/o_dlth update on that same edge and hold until the next completion.
  - Outputs are not disturbed during a run.
- o_busy: high for exactly L cycles (all non-IDLE states); low while o_valid is high.
- i_start while busy: ignored, not queued.
- i_start high in the o_valid cycle: accepted (FSM is in IDLE), giving back-to-back runs.
- Holding i_start high continuously: restart every L+1 cycles.
- Reset asserted mid-run: aborts the run; outputs clear to 0; no o_valid pulse follows.
- a = 0 or a = ONE: derivative is 0, so the delta is 0 regardless of t.

Test Plan:
1. Nominal run.
   - Stimulus: a = {0x00800000, 0x00800000}, t = {0x01000000 (j0), 0x00000000 (j1)}, h all 0x00800000, w[0][i] = 0x01000000, w[1][i] = 0.
   - Response: o_dlto = {j0: 0xFFE00000, j1: 0x00200000}, every o_dlth = 0xFFF80000.
2. Timing.
   - Stimulus: same as scenario 1, single-cycle i_start.
   - Response: o_busy high exactly 16 cycles; o_valid single pulse exactly 16 edges after the start edge; outputs unchanged before that edge.
3. Ignored and back-to-back starts.
   - Stimulus: i_start pulsed at busy cycle 5, then i_start high during the o_valid cycle.
   - Response: first pulse has no effect; second run's o_valid arrives 16 edges later with results from the inputs captured at that start.
4. Saturation.
   - Stimulus: a_0 = 0x7FFFFFFF, t_0 = 0.
   - Response: o_dlto j0 = 0x80000000 (both products saturate); other lanes unaffected.
5. Zero derivative.
   - Stimulus: a = {0x00000000, 0x01000000}, any t.
   - Response: o_dlto = 0, all o_dlth = 0.
6. Reset mid-run.
   - Stimulus: drive rst=0 asynchronously at cycle 8 of a run, release 2 cycles later.
   - Response: o_busy, o_valid, o_dlto, o_dlth go to 0 immediately; no o_valid pulse until a new i_start.
